// File: rtl/carfield_domain_seq_if.sv
// Request/status bundle between the Carfield register file and the domain sequencer.
// Signal suffixes are from the sequencer's point of view (slave modport).
interface carfield_domain_seq_if #(
  parameter int unsigned NumDomains = 6
);
  logic [NumDomains-1:0] domain_en_i;
  logic [NumDomains-1:0] domain_swrst_i;
  logic [NumDomains-1:0] domain_isolated_i;
  logic [NumDomains-1:0] domain_clk_en_o;
  logic [NumDomains-1:0] domain_rst_no;
  logic [NumDomains-1:0] domain_isolate_o;
  logic [NumDomains-1:0] domain_on_o;
  logic [NumDomains-1:0] iso_err_o;
  logic                  busy_o;

  modport master (
    output domain_en_i, domain_swrst_i, domain_isolated_i,
    input  domain_clk_en_o, domain_rst_no, domain_isolate_o, domain_on_o, iso_err_o, busy_o
  );

  modport slave (
    input  domain_en_i, domain_swrst_i, domain_isolated_i,
    output domain_clk_en_o, domain_rst_no, domain_isolate_o, domain_on_o, iso_err_o, busy_o
  );
endinterface

// File: rtl/carfield_domain_seq.sv
// Power-domain sequencer: one shared FSM walks a round-robin selected domain through
// isolate / reset / clock-gate steps; all outputs registered, no backpressure (level requests).
module carfield_domain_seq #(
  parameter int unsigned NumDomains       = 6,
  parameter int unsigned ClkSettleCycles  = 4,
  parameter int unsigned RstHoldCycles    = 16,
  parameter int unsigned IsoTimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  carfield_domain_seq_if.slave bus
);
  localparam int unsigned MaxA      = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
  localparam int unsigned MaxCycles = (MaxA > IsoTimeoutCycles) ? MaxA : IsoTimeoutCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned IdxW      = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t ClkLoad = cnt_t'(ClkSettleCycles - 1);
  localparam cnt_t RstLoad = cnt_t'(RstHoldCycles - 1);
  localparam cnt_t IsoLoad = cnt_t'(IsoTimeoutCycles - 1);

  typedef enum logic [2:0] {IDLE, CLK_ON, RST_HOLD, RST_REL, ISO_REQ, RST_ASSERT} state_e;
  typedef enum logic [1:0] {OP_UP, OP_DOWN, OP_SWRST} op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  idx_t                  dom_q, dom_d, ptr_q, ptr_d;
  cnt_t                  cnt_q, cnt_d;
  logic [NumDomains-1:0] clk_en_q, clk_en_d, rst_n_q, rst_n_d, iso_q, iso_d;
  logic [NumDomains-1:0] on_q, on_d, err_q, err_d, pend_q, pend_d;
  logic [NumDomains-1:0] sync1_q, sync2_q;
  logic                  busy_q, busy_d;

  logic [NumDomains-1:0] pending;
  logic                  sel_vld;
  idx_t                  sel_idx;
  int unsigned           scan_idx;

  assign pending = (bus.domain_en_i ^ on_q) | pend_q;

  // First pending domain at or after the pointer, wrapping.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = ptr_q;
    scan_idx = 0;
    for (int unsigned k = 0; k < NumDomains; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NumDomains) scan_idx = scan_idx - NumDomains;
      if (!sel_vld && pending[idx_t'(scan_idx)]) begin
        sel_vld = 1'b1;
        sel_idx = idx_t'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dom_d    = dom_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    rst_n_d  = rst_n_q;
    iso_d    = iso_q;
    on_d     = on_q;
    err_d    = err_q;
    busy_d   = busy_q;
    pend_d   = pend_q | (bus.domain_swrst_i & on_q);

    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          dom_d  = sel_idx;
          busy_d = 1'b1;
          ptr_d  = (32'(sel_idx) == NumDomains - 1) ? '0 : sel_idx + idx_t'(1);
          if (!on_q[sel_idx]) begin
            op_d              = OP_UP;
            clk_en_d[sel_idx] = 1'b1;
            cnt_d             = ClkLoad;
            state_d           = CLK_ON;
          end else begin
            op_d            = bus.domain_en_i[sel_idx] ? OP_SWRST : OP_DOWN;
            iso_d[sel_idx]  = 1'b1;
            on_d[sel_idx]   = 1'b0;
            pend_d[sel_idx] = 1'b0;
            cnt_d           = IsoLoad;
            state_d         = ISO_REQ;
          end
        end
      end
      CLK_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = RstLoad;
          state_d = RST_HOLD;
        end else cnt_d = cnt_q - 1'b1;
      end
      RST_HOLD: begin
        if (cnt_q == '0) begin
          rst_n_d[dom_q] = 1'b1;
          state_d        = RST_REL;
        end else cnt_d = cnt_q - 1'b1;
      end
      // De-isolation is applied on the edge that returns to IDLE.
      RST_REL: begin
        iso_d[dom_q] = 1'b0;
        on_d[dom_q]  = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      ISO_REQ: begin
        if (sync2_q[dom_q] || cnt_q == '0) begin
          err_d[dom_q]   = !sync2_q[dom_q];
          rst_n_d[dom_q] = 1'b0;
          cnt_d          = RstLoad;
          state_d        = RST_ASSERT;
        end else cnt_d = cnt_q - 1'b1;
      end
      RST_ASSERT: begin
        if (cnt_q == '0) begin
          if (op_q == OP_DOWN) begin
            clk_en_d[dom_q] = 1'b0;
            busy_d          = 1'b0;
            state_d         = IDLE;
          end else begin
            rst_n_d[dom_q] = 1'b1;
            state_d        = RST_REL;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= OP_UP;
      dom_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      clk_en_q <= '0;
      rst_n_q  <= '0;
      iso_q    <= '1;
      on_q     <= '0;
      err_q    <= '0;
      pend_q   <= '0;
      busy_q   <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dom_q    <= dom_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      iso_q    <= iso_d;
      on_q     <= on_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      sync1_q  <= bus.domain_isolated_i;
      sync2_q  <= sync1_q;
    end
  end

  assign bus.domain_clk_en_o  = clk_en_q;
  assign bus.domain_rst_no    = rst_n_q;
  assign bus.domain_isolate_o = iso_q;
  assign bus.domain_on_o      = on_q;
  assign bus.iso_err_o        = err_q;
  assign bus.busy_o           = busy_q;
endmodule

// File: tb/tb_carfield_domain_seq.sv
// Bench for carfield_domain_seq: a timeline reference model pushes the expected outputs
// after every clock edge; a monitor pops and compares on the falling edge.
module tb_carfield_domain_seq;
  localparam int N = 6, CLKS = 4, RSTH = 16, ISOT = 8;
  localparam int OP_UP = 0, OP_DN = 1, OP_SW = 2;

  typedef struct packed {
    logic [N-1:0] clk_en, rst_n, iso, on, err;
    logic         busy;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carfield_domain_seq_if #(.NumDomains(N)) bus ();

  carfield_domain_seq #(
    .NumDomains(N), .ClkSettleCycles(CLKS), .RstHoldCycles(RSTH), .IsoTimeoutCycles(ISOT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int tests = 0, fails = 0;
  snap_t exp_q[$];

  // Reference model state
  logic [N-1:0] m_clk = '0, m_rstn = '0, m_iso = '1, m_on = '0, m_err = '0, m_pend = '0;
  logic [N-1:0] on_old, pend_old, pend_now;
  bit   m_busy = 0, m_idle = 1, m_acked = 0, found;
  int   m_ptr = 0, m_dom = 0, m_op = 0, m_len = 1, m_t = 0, m_s = 0, r, dd;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_clk = '0; m_rstn = '0; m_iso = '1; m_on = '0; m_err = '0; m_pend = '0;
      m_busy = 0; m_idle = 1; m_ptr = 0; m_t = 0; m_s = 0;
      exp_q.delete();
    end else begin
      m_t++;
      on_old   = m_on;
      pend_old = m_pend;
      m_pend   = m_pend | (bus.domain_swrst_i & on_old);
      if (m_idle) begin
        pend_now = (bus.domain_en_i ^ on_old) | pend_old;
        found = 0;
        for (int k = 0; k < N; k++) begin
          dd = (m_ptr + k) % N;
          if (!found && pend_now[dd]) begin found = 1; m_dom = dd; end
        end
        if (found) begin
          m_s = m_t; m_idle = 0; m_busy = 1; m_ptr = (m_dom + 1) % N;
          if (bus.domain_en_i[m_dom] && !on_old[m_dom]) begin
            m_op = OP_UP;
            m_clk[m_dom] = 1'b1;
          end else begin
            m_op = bus.domain_en_i[m_dom] ? OP_SW : OP_DN;
            m_iso[m_dom] = 1'b1; m_on[m_dom] = 1'b0; m_pend[m_dom] = 1'b0;
            m_acked = bus.domain_isolated_i[m_dom];
            m_len   = m_acked ? 1 : ISOT;
          end
        end
      end else begin
        r = m_t - m_s;
        if (m_op == OP_UP) begin
          if (r == CLKS + RSTH) m_rstn[m_dom] = 1'b1;
          if (r == CLKS + RSTH + 1) begin
            m_iso[m_dom] = 1'b0; m_on[m_dom] = 1'b1; m_busy = 0; m_idle = 1;
          end
        end else begin
          if (r == m_len) begin m_err[m_dom] = !m_acked; m_rstn[m_dom] = 1'b0; end
          if (m_op == OP_DN && r == m_len + RSTH) begin
            m_clk[m_dom] = 1'b0; m_busy = 0; m_idle = 1;
          end
          if (m_op == OP_SW && r == m_len + RSTH) m_rstn[m_dom] = 1'b1;
          if (m_op == OP_SW && r == m_len + RSTH + 1) begin
            m_iso[m_dom] = 1'b0; m_on[m_dom] = 1'b1; m_busy = 0; m_idle = 1;
          end
        end
      end
      exp_q.push_back('{m_clk, m_rstn, m_iso, m_on, m_err, m_busy});
    end
  end

  snap_t mon_e, mon_a;
  initial forever begin
    @(negedge clk);
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{bus.domain_clk_en_o, bus.domain_rst_no, bus.domain_isolate_o,
                bus.domain_on_o, bus.iso_err_o, bus.busy_o};
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL cycle_check t=%0t clk_en %h want %h, rst_n %h want %h, iso %h want %h, on %h want %h, err %h want %h, busy %b want %b",
                 $time, mon_a.clk_en, mon_e.clk_en, mon_a.rst_n, mon_e.rst_n, mon_a.iso, mon_e.iso,
                 mon_a.on, mon_e.on, mon_a.err, mon_e.err, mon_a.busy, mon_e.busy);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset(input string name);
    tests++;
    if (bus.domain_clk_en_o !== 6'h00 || bus.domain_rst_no !== 6'h00 || bus.domain_isolate_o !== 6'h3F ||
        bus.domain_on_o !== 6'h00 || bus.iso_err_o !== 6'h00 || bus.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL %s clk_en=%h rst_n=%h iso=%h on=%h err=%h busy=%b, want 00 00 3f 00 00 0", name,
               bus.domain_clk_en_o, bus.domain_rst_no, bus.domain_isolate_o, bus.domain_on_o,
               bus.iso_err_o, bus.busy_o);
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while (!(m_idle && ((bus.domain_en_i ^ m_on) == '0) && m_pend == '0) && cnt < 3000) begin
      step(1);
      cnt++;
    end
    tests++;
    if (cnt >= 3000) begin
      fails++;
      $display("FAIL drain_timeout waited %0d cycles, want < 3000", cnt);
    end
    step(2);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  int idx;
  initial begin
    bus.domain_en_i = '0; bus.domain_swrst_i = '0; bus.domain_isolated_i = '0;
    rst_n = 1'b0;
    step(3);
    check_reset("reset_hold");
    rst_n = 1'b1;
    step(3);
    check_reset("reset_release");

    // Power-up of domain 3, then power-down with acknowledge high.
    bus.domain_en_i[3] = 1'b1; drain();
    bus.domain_isolated_i = '1; step(3);
    bus.domain_en_i[3] = 1'b0; drain();
    // Stuck acknowledge -> timeout, error stays sticky until a good acknowledge.
    bus.domain_isolated_i = '0; step(3);
    bus.domain_en_i[3] = 1'b1; drain();
    bus.domain_en_i[3] = 1'b0; drain();
    bus.domain_isolated_i = '1; step(3);
    bus.domain_en_i[3] = 1'b1; drain();
    bus.domain_en_i[3] = 1'b0; drain();

    // Reset asserted mid-sequence.
    bus.domain_en_i[0] = 1'b1; step(6);
    #1 rst_n = 1'b0;
    #1 check_reset("reset_midseq");
    bus.domain_en_i = '0;
    step(2);
    rst_n = 1'b1;
    step(3);

    // All domains at once, then simultaneous swrst on 1 and 4.
    bus.domain_en_i = 6'h3F; drain();
    bus.domain_swrst_i = 6'b010010; step(1);
    bus.domain_swrst_i = '0; drain();

    // Drop domain 2 enable while its power-up is in reset hold.
    bus.domain_en_i[2] = 1'b0; drain();
    bus.domain_en_i[2] = 1'b1; step(10);
    bus.domain_en_i[2] = 1'b0; drain();

    // Randomised traffic.
    repeat (6) begin
      bus.domain_isolated_i = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
      step(3);
      repeat (150) begin
        if ($urandom_range(0, 11) == 0) begin
          idx = $urandom_range(0, N - 1);
          bus.domain_en_i[idx] = ~bus.domain_en_i[idx];
        end
        bus.domain_swrst_i = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
        step(1);
      end
      bus.domain_swrst_i = '0;
      drain();
    end

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/carfield_domain_seq.md
Name: carfield_domain_seq

Overview:
- Central power-domain sequencer for the six clock-gateable Carfield domains (periph, safed, secd, integer cluster, FP cluster, L2).
- Turns per-domain enable requests and software-reset pulses from the Carfield register file into ordered isolate, reset and clock-gate control.
- Services one domain at a time with a single shared FSM and round-robin arbitration.
- Its clock-enable and reset outputs feed the domain clock gates and reset generators, and are mirrored on the debug-signal struct.

Parameters:
- NumDomains, 6: number of sequenced domains; bit index = domain index.
- ClkSettleCycles, 4: cycles the clock runs with reset held before reset release starts counting; range 1..255.
- RstHoldCycles, 16: cycles reset is held asserted; range 1..255.
- IsoTimeoutCycles, 256: maximum wait for an isolation acknowledge; range 1..65535.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- domain_en_i  in  NumDomains  level; 1 = domain requested on.
- domain_swrst_i  in  NumDomains  1-cycle pulse; request a reset of an on domain.
- domain_isolated_i  in  NumDomains  isolation acknowledge from the domain AXI isolate cells.
- domain_clk_en_o  out  NumDomains  clock-gate enable.
- domain_rst_no  out  NumDomains  domain reset, active-low.
- domain_isolate_o  out  NumDomains  isolation request.
- domain_on_o  out  NumDomains  domain fully up (status).
- iso_err_o  out  NumDomains  sticky isolation-timeout flag.
- busy_o  out  1  sequencer active.

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low.
- Reset values:
  - clk_en = 0, rst_n = 0, isolate = all ones, on = 0, iso_err = 0, busy = 0.
  - FSM in IDLE; round-robin pointer = 0.
- Pending state:
  - swrst_pend[d] is set by a domain_swrst_i[d] pulse, but only while on[d] = 1.
  - A domain is pending if domain_en_i[d] != on[d] or swrst_pend[d] = 1.
- Arbitration (IDLE):
  - Select the first pending domain at or after the pointer, wrapping around.
  - Latch the domain index and the operation. Op priority: power-up if en = 1 and on = 0; power-down if en = 0 and on = 1; otherwise swrst.
  - Pointer becomes the selected index + 1, modulo NumDomains.
  - busy = 1 from the cycle after selection until the cycle IDLE is re-entered.
- All outputs are registered and update on the state-entry edge.
- Power-up:
  - CLK_ON: clk_en[d] = 1; stay ClkSettleCycles.
  - RST_HOLD: stay RstHoldCycles.
  - RST_REL: rst_n[d] = 1; 1 cycle.
  - DEISO: isolate[d] = 0, on[d] = 1; then IDLE.
- Power-down:
  - ISO_REQ: isolate[d] = 1, on[d] = 0. Wait for domain_isolated_i[d] = 1, synchronised through 2 flops.
    - If the acknowledge arrives: iso_err[d] is cleared.
    - If IsoTimeoutCycles elapse first: iso_err[d] = 1 and the sequence proceeds.
  - RST_ASSERT: rst_n[d] = 0; stay RstHoldCycles.
  - CLK_OFF: clk_en[d] = 0; then IDLE.
- Software reset:
  - ISO_REQ, then RST_ASSERT, then RST_REL, then DEISO.
  - Clock stays enabled throughout; swrst_pend[d] is cleared on entering ISO_REQ.
- Requests arriving mid-sequence:
  - Changes to domain_en_i for the active domain are ignored until IDLE and re-evaluated there. An on-off-on toggle seen only in IDLE after completion therefore causes no action.
  - A swrst pulse for a domain that is off, or that is mid power-up, is dropped.
- Counter: one shared counter, width clog2 of the largest parameter + 1; loaded on state entry, moves on at 0.
- Simultaneous pending domains are served strictly one after another; no overlap of sequences.
- Reset asserted mid-sequence: immediate return to the reset values. All domains end up gated, reset and isolated.

Test Plan:
- Reset check: hold rst_ni = 0 -> clk_en = 6'h00, rst_n = 6'h00, isolate = 6'h3F, busy = 0. Release with domain_en_i = 0 -> outputs unchanged.
- Power-up, defaults, domain_en_i[3] rises at edge 0 -> clk_en[3] = 1 at edge 1, rst_n[3] = 1 at edge 21, isolate[3] = 0 and on[3] = 1 at edge 22, busy low after edge 22.
- Power-down of domain 3 with the acknowledge tied high -> isolate[3] = 1, then after the synchroniser rst_n[3] = 0, then clk_en[3] = 0 RstHoldCycles later; iso_err[3] stays 0.
- Isolation timeout, acknowledge stuck low, IsoTimeoutCycles = 8 -> iso_err[3] = 1 after 8 cycles in ISO_REQ, then rst_n[3] = 0 and clk_en[3] = 0; iso_err[3] stays set until a later successful acknowledge.
- Arbitration: domain_en_i = 6'h3F in one cycle from reset -> domains 0,1,2,3,4,5 powered up in order, no overlapping clk_en transitions.
  - Then swrst pulses on domains 1 and 4 together while the pointer is 0 -> domain 1 served first, then domain 4; clk_en stays 1; each rst_n is low for 16 cycles.
- Mid-sequence: domain_en_i[2] dropped during RST_HOLD of its power-up -> power-up completes (on[2] = 1), then a power-down starts from IDLE.
  - rst_ni pulsed low mid-sequence -> all outputs return to reset values immediately.
